// File: rtl/usrt_tx_top.sv
// Synchronous serial (USRT) frame transmitter: start bit, LSB-first payload, parity and stop bit,
// paced by falling edges of an externally supplied bit clock sampled in the clk domain.
module usrt_tx_top #(
    parameter int                   DATA_BITS = 8,
    parameter logic [DATA_BITS-1:0] INIT_DATA = 8'h00
) (
    input  logic clk,
    input  logic rst,
    input  logic usrt_clk,
    input  logic start,
    input  logic sw6,
    output logic RTS,
    output logic TXD
);

    localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;

    state_t               r_state;
    logic                 r_usrt_q;
    logic [DATA_BITS-1:0] r_payload;
    logic [DATA_BITS-1:0] r_shift;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic                 r_parity;
    logic                 w_fe;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    // Bit tick uses the live input so the FSM reacts on the same clk edge the fall is seen.
    assign w_fe = r_usrt_q & ~usrt_clk;

    // Edge-detect register and transmit FSM with registered TXD/RTS.
    always_ff @(posedge clk) begin
        r_usrt_q <= usrt_clk;
        if (rst) begin
            r_state   <= IDLE;
            TXD       <= 1'b1;
            RTS       <= 1'b0;
            r_payload <= INIT_DATA;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
        end else if (w_fe) begin
            case (r_state)
                IDLE: begin
                    TXD <= 1'b1;
                    if (start) begin
                        r_shift  <= r_payload;
                        r_parity <= parity_bit(r_payload, sw6);
                        RTS      <= 1'b1;
                        r_state  <= SETUP;
                    end else begin
                        RTS     <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                SETUP: begin
                    TXD     <= 1'b0;
                    r_state <= START;
                end
                START: begin
                    TXD       <= r_shift[0];
                    r_bit_cnt <= '0;
                    r_state   <= DATA;
                end
                DATA: begin
                    if (r_bit_cnt < LAST_BIT) begin
                        r_shift   <= r_shift >> 1;
                        TXD       <= r_shift[1];
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end else begin
                        TXD     <= r_parity;
                        r_state <= PARITY;
                    end
                end
                PARITY: begin
                    TXD     <= 1'b1;
                    r_state <= STOP;
                end
                STOP: begin
                    TXD       <= 1'b1;
                    RTS       <= 1'b0;
                    r_payload <= r_payload + {{(DATA_BITS-1){1'b0}}, 1'b1};
                    r_state   <= IDLE;
                end
                default: begin
                    TXD     <= 1'b1;
                    RTS     <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usrt_tx_top.sv
// Directed-plus-random bench for usrt_tx_top; a frame-level reference model predicts
// RTS/TXD for every bit tick.
module tb_usrt_tx_top;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic usrt_clk = 1'b0;
    logic start = 1'b0;
    logic sw6 = 1'b0;
    logic RTS;
    logic TXD;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0]  exp_q[$];
    logic [7:0]  m_payload = 8'h00;
    logic        last_rts = 1'b0;
    logic        last_txd = 1'b1;
    logic [11:0] cap = 12'h000;

    usrt_tx_top dut (
        .clk      (clk),
        .rst      (rst),
        .usrt_clk (usrt_clk),
        .start    (start),
        .sw6      (sw6),
        .RTS      (RTS),
        .TXD      (TXD)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check12(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: a whole frame is queued when one launches (13 ticks incl. return to idle).
    task automatic model_tick(output logic e_rts, output logic e_txd);
        if (exp_q.size() == 0 && start) begin
            exp_q.push_back(2'b11);
            exp_q.push_back(2'b10);
            for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, m_payload[i]});
            exp_q.push_back({1'b1, (^m_payload) ^ sw6});
            exp_q.push_back(2'b11);
            exp_q.push_back(2'b01);
            m_payload = m_payload + 8'd1;
        end
        if (exp_q.size() == 0) begin
            e_rts = 1'b0;
            e_txd = 1'b1;
        end else begin
            {e_rts, e_txd} = exp_q.pop_front();
        end
    endtask

    task automatic do_tick(input int hi, input int lo);
        logic e_rts, e_txd;
        @(negedge clk);
        usrt_clk = 1'b1;
        repeat (hi) @(negedge clk);
        usrt_clk = 1'b0;
        @(posedge clk);
        #1;
        model_tick(e_rts, e_txd);
        check("tick_rts", RTS, e_rts);
        check("tick_txd", TXD, e_txd);
        last_rts = e_rts;
        last_txd = e_txd;
        cap = {cap[10:0], TXD};
        repeat (lo - 1) @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_rts", RTS, 1'b0);
        check("reset_txd", TXD, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_payload = 8'h00;
        last_rts = 1'b0;
        last_txd = 1'b1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick(1, 1);
    endtask

    initial begin
        // 1-2: back-to-back frames, even parity
        do_reset();
        start = 1'b1;
        sw6 = 1'b0;
        ticks(12);
        check12("frame0_even", cap, 12'h801);
        ticks(1);
        ticks(12);
        check12("frame1_even", cap, 12'hA03);
        ticks(1);
        ticks(12);
        check12("frame2_even", cap, 12'h903);
        ticks(1);

        // 3: odd parity, sw6 toggled mid-frame
        do_reset();
        sw6 = 1'b1;
        ticks(4);
        sw6 = 1'b0;
        ticks(8);
        check12("frame0_odd", cap, 12'h803);
        ticks(1);

        // 4: reset during DATA aborts the frame
        do_reset();
        ticks(5);
        do_reset();
        ticks(12);
        check12("after_abort", cap, 12'h801);
        ticks(1);

        // 5: start low idles; start dropped mid-frame completes the frame
        do_reset();
        start = 1'b0;
        for (int i = 0; i < 40; i++) do_tick($urandom_range(1, 3), $urandom_range(1, 3));
        start = 1'b1;
        ticks(6);
        start = 1'b0;
        ticks(20);

        // 6: stalled bit clock freezes outputs, then run to payload wrap
        do_reset();
        start = 1'b1;
        ticks(5);
        repeat (50) begin
            @(posedge clk);
            #1;
            check("stall_rts", RTS, last_rts);
            check("stall_txd", TXD, last_txd);
        end
        for (int i = 0; i < 13 * 256 - 5; i++) begin
            sw6 = 1'($urandom_range(0, 1));
            do_tick(1, 1);
        end
        sw6 = 1'b0;
        ticks(12);
        check12("wrap_frame", cap, 12'h801);
        ticks(1);

        // Random phase: random start/sw6 and bit-clock duty
        for (int i = 0; i < 300; i++) begin
            start = ($urandom_range(0, 3) != 0);
            sw6 = 1'($urandom_range(0, 1));
            do_tick($urandom_range(1, 3), $urandom_range(1, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
